// File: rtl/mips_shift_pkg.sv
// Shared constants and types for the multi-cycle MIPS shifter.
package mips_shift_pkg;

  // Shift modes as decoded from the instruction
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/mips_shift_step.sv
// One combinational shift step: shifts a word by 0..2^SHAMT_W-1 in the given
// mode and reports the last bit shifted out (ROR: result MSB, 0 for no shift).
module mips_shift_step
  import mips_shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] amt_i,
  input  logic [1:0]         mode_i,
  output logic [WIDTH-1:0]   result_o,
  output logic               carry_o
);

  localparam logic [SHAMT_W:0] WidthAmt = (SHAMT_W + 1)'(WIDTH);

  // One guard bit beyond the word catches the last bit shifted out
  logic [WIDTH:0]   left_ext;
  logic [WIDTH:0]   right_ext;
  logic [WIDTH:0]   sra_ext;
  logic [WIDTH-1:0] rot;

  // Compute every mode's result, then select by mode
  always_comb begin
    result_o  = '0;
    carry_o   = 1'b0;
    left_ext  = {1'b0, data_i} << amt_i;
    right_ext = {data_i, 1'b0} >> amt_i;
    sra_ext   = $signed({data_i, 1'b0}) >>> amt_i;
    rot       = (data_i >> amt_i) | (data_i << (WidthAmt - {1'b0, amt_i}));
    unique case (mode_i)
      SH_SLL: {carry_o, result_o} = left_ext;
      SH_SRL: {result_o, carry_o} = right_ext;
      SH_SRA: {result_o, carry_o} = sra_ext;
      SH_ROR: begin
        result_o = rot;
        carry_o  = (amt_i != '0) & rot[WIDTH-1];
      end
    endcase
  end

endmodule

// File: rtl/mips_seq_shifter.sv
// Multi-cycle shifter: accepts one request, shifts up to STEP bits per cycle,
// then holds the result until the consumer takes it.
module mips_seq_shifter
  import mips_shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STEP    = 4,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry
);

  // Remaining never exceeds WIDTH-1, so clamping STEP there keeps it in SHAMT_W bits
  localparam int unsigned StepClamp = (STEP > WIDTH - 1) ? WIDTH - 1 : STEP;
  localparam logic [SHAMT_W-1:0] StepAmt = SHAMT_W'(StepClamp);

  shift_state_e       state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               carry_q, carry_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         mode_q, mode_d;

  logic [SHAMT_W-1:0] step_amt;
  logic [WIDTH-1:0]   step_result;
  logic               step_carry;

  // Distance covered this cycle: min(remaining, STEP)
  always_comb begin
    step_amt = (rem_q > StepAmt) ? StepAmt : rem_q;
  end

  mips_shift_step #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_step (
    .data_i  (data_q),
    .amt_i   (step_amt),
    .mode_i  (mode_q),
    .result_o(step_result),
    .carry_o (step_carry)
  );

  // Next-state logic: accept, iterate, hand off
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    carry_d = carry_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = in_mode;
          rem_d   = in_shamt;
          carry_d = 1'b0;
          state_d = (in_shamt == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        data_d  = step_result;
        carry_d = step_carry;
        rem_d   = rem_q - step_amt;
        if (rem_d == '0) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any request in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      carry_q <= 1'b0;
      rem_q   <= '0;
      mode_q  <= SH_SLL;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
    end
  end

  // Handshake flags are pure state decodes; results come straight from registers
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    out_data  = data_q;
    out_carry = carry_q;
  end

endmodule

// File: tb/tb_mips_seq_shifter.sv
// Bench for mips_seq_shifter: three instances (STEP 1, 4, 32) share the same
// request stream and are checked every cycle against a shift/latency model.
module tb_mips_seq_shifter;
  import mips_shift_pkg::*;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_mode = '0;
  logic        out_ready = 1'b1;

  logic        rdy [NI];
  logic        ov  [NI];
  logic [31:0] od  [NI];
  logic        oc  [NI];

  always #5 clk = ~clk;

  mips_seq_shifter #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_carry(oc[0])
  );
  mips_seq_shifter #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_carry(oc[1])
  );
  mips_seq_shifter #(.WIDTH(32), .STEP(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .out_carry(oc[2])
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int step_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 32;
  endfunction

  // Whole-shift reference: {carry, result}; last bit out is original bit s-1 (or 32-s)
  function automatic logic [32:0] ref_shift(input logic [1:0] m, input logic [4:0] s,
                                            input logic [31:0] d);
    logic [31:0] r;
    logic        c;
    int          k;
    k = int'(s);
    c = 1'b0;
    case (m)
      SH_SLL: begin r = d << k; if (k != 0) c = d[32-k]; end
      SH_SRL: begin r = d >> k; if (k != 0) c = d[k-1]; end
      SH_SRA: begin r = 32'($signed(d) >>> k); if (k != 0) c = d[k-1]; end
      default: begin r = (d >> k) | (d << (32 - k)); if (k != 0) c = r[31]; end
    endcase
    return {c, r};
  endfunction

  // Model: per instance, busy flag, edge at which result is due, expected value
  int          cyc = 0;
  logic        busy [NI];
  int          due  [NI];
  int          acc  [NI];
  logic [32:0] expv [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) busy[i] <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < NI; i++) begin
        if (!busy[i]) begin
          if (in_valid) begin
            busy[i] <= 1'b1;
            acc[i]  <= cyc + 1;
            due[i]  <= cyc + 1 + (int'(in_shamt) + step_of(i) - 1) / step_of(i);
            expv[i] <= ref_shift(in_mode, in_shamt, in_data);
          end
        end else if (cyc >= due[i] && out_ready) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  // Compare process, plus observed latency and last delivered result per instance
  int          lat  [NI];
  logic        ovp  [NI];
  logic [32:0] last [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic exp_ov;
      exp_ov = busy[i] && (cyc >= due[i]);
      chk($sformatf("in_ready[%0d]", i), 33'(rdy[i]), 33'(!busy[i]));
      chk($sformatf("out_valid[%0d]", i), 33'(ov[i]), 33'(exp_ov));
      if (exp_ov) chk($sformatf("result[%0d]", i), {oc[i], od[i]}, expv[i]);
      if (ov[i] && !ovp[i]) lat[i] = cyc - acc[i];
      ovp[i] = ov[i];
      if (ov[i] && out_ready) last[i] = {oc[i], od[i]};
    end
  end

  task automatic wait_all_ready();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = rdy[0] && rdy[1] && rdy[2];
    end
    if (!ok) chk("wait_ready_timeout", 33'(0), 33'(1));
  endtask

  task automatic launch(input logic [1:0] m, input logic [4:0] s, input logic [31:0] d);
    wait_all_ready();
    in_valid = 1'b1;
    in_mode  = m;
    in_shamt = s;
    in_data  = d;
    @(negedge clk);
    // Scramble inputs: they must only matter at accept
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = 5'($urandom);
    in_mode  = 2'($urandom);
  endtask

  task automatic run(input logic [1:0] m, input logic [4:0] s, input logic [31:0] d);
    launch(m, s, d);
    wait_all_ready();
  endtask

  initial begin
    // Reset values
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_out_data[%0d]", i), 33'(od[i]), 33'(0));
      chk($sformatf("rst_out_carry[%0d]", i), 33'(oc[i]), 33'(0));
    end
    chk("rst_in_ready", 33'(rdy[1]), 33'(1));
    chk("rst_out_valid", 33'(ov[1]), 33'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Pin the model to hand-computed values
    chk("model_sll2", ref_shift(SH_SLL, 5'd2, 32'h0000_0001), 33'h0_0000_0004);
    chk("model_srl4", ref_shift(SH_SRL, 5'd4, 32'hF000_000F), 33'h1_0F00_0000);
    chk("model_srl5", ref_shift(SH_SRL, 5'd5, 32'hF000_000F), 33'h0_0780_0000);
    chk("model_sra31", ref_shift(SH_SRA, 5'd31, 32'h8000_0000), 33'h0_FFFF_FFFF);
    chk("model_ror1", ref_shift(SH_ROR, 5'd1, 32'h0000_0001), 33'h1_8000_0000);

    // Directed vectors on the STEP=4 instance
    run(SH_SLL, 5'd2, 32'h0000_0001);
    chk("sll2_res", last[1], 33'h0_0000_0004);
    chk("sll2_lat", 33'(lat[1]), 33'(1));
    run(SH_SRL, 5'd4, 32'hF000_000F);
    chk("srl4_res", last[1], 33'h1_0F00_0000);
    chk("srl4_lat", 33'(lat[1]), 33'(1));
    run(SH_SRL, 5'd5, 32'hF000_000F);
    chk("srl5_res", last[1], 33'h0_0780_0000);
    chk("srl5_lat", 33'(lat[1]), 33'(2));
    run(SH_SRA, 5'd31, 32'h8000_0000);
    chk("sra31_res", last[1], 33'h0_FFFF_FFFF);
    chk("sra31_lat", 33'(lat[1]), 33'(8));
    chk("sra31_lat_step1", 33'(lat[0]), 33'(31));
    chk("sra31_lat_step32", 33'(lat[2]), 33'(1));
    run(SH_ROR, 5'd1, 32'h0000_0001);
    chk("ror1_res", last[1], 33'h1_8000_0000);
    for (int m = 0; m < 4; m++) begin
      run(2'(m), 5'd0, 32'hDEAD_BEEF);
      chk($sformatf("zero_res_m%0d", m), last[1], 33'h0_DEAD_BEEF);
      chk($sformatf("zero_lat_m%0d", m), 33'(lat[1]), 33'(0));
    end

    // Backpressure: result must hold and a second request must be ignored
    out_ready = 1'b0;
    launch(SH_SRL, 5'd5, 32'hF000_000F);
    begin
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge clk);
        ok = ov[0] && ov[1] && ov[2];
      end
      if (!ok) chk("bp_valid_timeout", 33'(0), 33'(1));
    end
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    in_shamt = 5'd3;
    in_mode  = SH_SLL;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold", {oc[1], od[1]}, 33'h0_0780_0000);
      chk("bp_in_ready", 33'(rdy[1]), 33'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 33'(rdy[1]), 33'(1));
    chk("bp_release_valid", 33'(ov[1]), 33'(0));

    // Random sweep across all three STEP values
    for (int n = 0; n < 40; n++) begin
      run(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom);
    end

    // Reset in the middle of a long shift
    launch(SH_SLL, 5'd20, 32'h0001_2345);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 33'(ov[1]), 33'(0));
    chk("midrst_data", 33'(od[1]), 33'(0));
    chk("midrst_carry", 33'(oc[1]), 33'(0));
    chk("midrst_ready", 33'(rdy[1]), 33'(1));
    @(negedge clk);
    rst_n = 1'b1;
    run(SH_SLL, 5'd20, 32'h0000_0001);
    chk("post_rst_res", last[1], 33'h0_0010_0000);
    chk("post_rst_lat", 33'(lat[1]), 33'(5));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard stop if something never returns
  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_seq_shifter.md
# mips_seq_shifter

Parametrised multi-cycle shifter for the MIPS datapath. It generalises the fixed left-by-2 address shifter to four modes: logical left, logical right, arithmetic right and rotate right. Shift amount, data width and per-cycle step size are all variable. It sits beside the ALU, serves SLL/SRL/SRA/SLLV/SRLV/SRAV and branch/jump offset scaling, and uses a valid/ready handshake on both sides so the control unit can stall on it.

## Interface
- `WIDTH`, 32: data width in bits; power of 2, ≥ 4.
- `STEP`, 4: maximum shift distance applied per cycle; power of 2, 1..WIDTH.
- `SHAMT_W`, $clog2(WIDTH): shift-amount width (derived; do not override).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request.
- `in_data`  in  WIDTH  operand.
- `in_shamt`  in  SHAMT_W  shift amount, 0..WIDTH-1.
- `in_mode`  in  2  SH_SLL / SH_SRL / SH_SRA / SH_ROR.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `out_data`  out  WIDTH  shifted result.
- `out_carry`  out  1  last bit shifted out; for ROR, the result MSB; 0 when shamt = 0.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - SHIFT: working.
  - DONE: `out_valid`=1.
- Accept occurs on an edge with `in_valid` & `in_ready`. On accept:
  - Latch data, mode, remaining = shamt, carry = 0.
  - Next state is DONE if shamt = 0, else SHIFT.
- Each SHIFT edge:
  - Step k = min(remaining, STEP).
  - Shift the working register by k in the latched mode.
  - remaining -= k.
  - carry = last bit shifted out in this step.
  - Go to DONE when the new remaining = 0.
- Mode rules:
  - SLL fills zeros at the LSB.
  - SRL fills zeros at the MSB.
  - SRA replicates the original sign bit.
  - ROR wraps LSBs into the MSB; carry = bit WIDTH-1 of the result.
- DONE: hold `out_data` and `out_carry` stable while `out_ready`=0. When `out_valid` & `out_ready`, go to IDLE.
- Busy behaviour: `in_ready` is 0 in SHIFT and DONE, and `in_valid` is ignored there. There is no accept in the DONE→IDLE cycle; at most one request is in flight.
- Inputs are sampled only at accept. Changes on `in_*` during SHIFT or DONE have no effect.
- Reset, including mid-operation: state IDLE, working register 0, carry 0, remaining 0. The request in flight is discarded with no output.

## Timing
- Reset values:
  - `in_ready`=1.
  - `out_valid`=0.
  - `out_data`=0.
  - `out_carry`=0.
- Latency: `out_valid` rises after edge E+ceil(shamt/STEP), where E is the accept edge. So shamt = 0 gives `out_valid` in the cycle after accept.
- Throughput: one request per ceil(shamt/STEP)+2 cycles with `out_ready` tied high.
- `in_ready` and `out_valid` are registered state decodes with no combinational path from inputs. `out_data` and `out_carry` are driven directly from registers.

## Structure
- Package `mips_shift_pkg`:
  - 2-bit mode constants SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROR=2'b11.
  - State encoding IDLE/SHIFT/DONE.
- Sub-module `mips_shift_step`:
  - Purely combinational.
  - Shifts a WIDTH-bit word by 0..STEP in a given mode.
  - Returns the shifted word and the carry bit.
  - Instantiated once.
- Top level holds the FSM, remaining counter, working register and carry register.

## Test plan
- SLL, shamt=2, data 0x0000_0001, STEP=4 → 0x0000_0004, carry 0, `out_valid` after accept+1 edge (matches the legacy fixed shifter).
- SRL, shamt=4, data 0xF000_000F → 0x0F00_0000, carry 1, one SHIFT cycle; shamt=5 instead → two SHIFT cycles, 0x0780_0000, carry 0.
- SRA, shamt=31, data 0x8000_0000 → 0xFFFF_FFFF, carry 0, 8 SHIFT cycles. ROR, shamt=1, data 0x0000_0001 → 0x8000_0000, carry 1.
- Backpressure: hold `out_ready`=0 for 3 cycles in DONE → `out_data`/`out_carry` stable, `in_ready`=0, second `in_valid` ignored; release → IDLE next edge.
- shamt=0, any mode, data 0xDEAD_BEEF → 0xDEAD_BEEF, carry 0. Sweep STEP ∈ {1, 4, 32} against a reference model for random data/shamt/mode.
- Assert `rst_n`=0 mid-SHIFT (SLL, shamt=20) → immediately `out_valid`=0, `out_data`=0, `in_ready`=1. After release, a new request completes correctly.
